pc_ir_unit: RTL

Program-counter and instruction-register stage of the 8-bit multicycle MIPS datapath, directly upstream of the control unit. It holds the byte-wide PC and assembles each 32-bit instruction from four byte fetches enabled by the control unit's one-hot `IRWrite`. It presents `Op`/`Funct` and the register fields back to the control unit and datapath, and latches memory read data into the MDR. A fetch-sequence checker flags malformed `IRWrite` sequences and reports when a complete instruction is held.

---
 rtl/mips8_pkg.sv | 30 +++
 rtl/ir_byte_sequencer.sv | 52 +++++
 rtl/pc_ir_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/mips8_pkg.sv
// Shared encodings and instruction field positions for the 8-bit multicycle MIPS datapath.
package mips8_pkg;

    typedef enum logic [1:0] {
        PC_ALURES = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RSVD   = 2'b11
    } pcsrc_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/ir_byte_sequencer.sv
// Tracks the expected next IR byte, reports a fully assembled instruction and
// latches any out-of-order IRWrite pattern.
module ir_byte_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] IRWrite,
    output logic       InstrValid,
    output logic       FetchError
);

    logic [1:0] expect_q, expect_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    always_comb begin
        expect_d = expect_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (IRWrite == 4'b0001) begin
            valid_d  = 1'b0;
            expect_d = 2'd1;
        end else if (IRWrite != 4'b0000) begin
            // Byte 0 is only legal as a restart, so E0 accepts nothing else.
            if ((expect_q != 2'd0) && (IRWrite == (4'b0001 << expect_q))) begin
                expect_d = expect_q + 2'd1;
                if (expect_q == 2'd3) begin
                    valid_d = 1'b1;
                end
            end else begin
                err_d    = 1'b1;
                valid_d  = 1'b0;
                expect_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            expect_q <= 2'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            expect_q <= expect_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign InstrValid = valid_q;
    assign FetchError = err_q;

endmodule

// File: rtl/pc_ir_unit.sv
// PC, byte-assembled instruction register and MDR feeding the multicycle
// control unit, with a fetch-order checker on IRWrite.
module pc_ir_unit
    import mips8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       IRWrite,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic             Zero,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] MemData,
    output logic [WIDTH-1:0] PC,
    output logic [31:0]      Instr,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [7:0]       Imm,
    output logic [WIDTH-1:0] Data,
    output logic             InstrValid,
    output logic             FetchError
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] data_q;
    logic             pc_en;

    assign pc_en = PCWrite | (Branch & Zero);

    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            case (PCSrc)
                PC_ALURES: pc_d = ALUResult;
                PC_ALUOUT: pc_d = ALUOut;
                // Jump target uses the instruction held before this edge.
                PC_JUMP:   pc_d = WIDTH'({instr_q[5:0], 2'b00});
                default:   pc_d = pc_q;
            endcase
        end
    end

    always_comb begin
        instr_d = instr_q;
        for (int k = 0; k < 4; k++) begin
            if (IRWrite[k]) begin
                instr_d[8*k +: 8] = MemData[7:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= MemData;
        end
    end

    ir_byte_sequencer u_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .IRWrite    (IRWrite),
        .InstrValid (InstrValid),
        .FetchError (FetchError)
    );

    assign PC    = pc_q;
    assign Instr = instr_q;
    assign Data  = data_q;
    assign Op    = instr_q[OP_LSB +: 6];
    assign Rs    = instr_q[RS_LSB +: 5];
    assign Rt    = instr_q[RT_LSB +: 5];
    assign Rd    = instr_q[RD_LSB +: 5];
    assign Funct = instr_q[FUNCT_LSB +: 6];
    assign Imm   = instr_q[IMM_LSB +: 8];

endmodule
